// File: rtl/ms2xs_pkg.sv
// ============================================================================
// Module  : ms2xs_pkg
// Brief   : Shared ternary code constants, FSM state type and clog2 helper
//           for the ms2xs ternary-by-modular polynomial multiplier.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ms2xs_pkg;

    localparam logic [1:0] C_TRIT_ZERO = 2'b00;
    localparam logic [1:0] C_TRIT_POS  = 2'b01;
    localparam logic [1:0] C_TRIT_RSV  = 2'b10;
    localparam logic [1:0] C_TRIT_NEG  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ms2xs_au.sv
// ============================================================================
// Module  : ms2xs_au
// Brief   : Combinational accumulator update: o_sum = i_acc + code*i_h,
//           wrapping modulo 2^LOGQ. Reserved and zero codes pass i_acc.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms2xs_au
    import ms2xs_pkg::*;
#(
    parameter int LOGQ = 6
) (
    input  logic [LOGQ-1:0] i_acc,
    input  logic [LOGQ-1:0] i_h,
    input  logic [1:0]      i_code,
    output logic [LOGQ-1:0] o_sum
);

    always_comb begin
        o_sum = i_acc;
        case (i_code)
            C_TRIT_POS: o_sum = i_acc + i_h;
            C_TRIT_NEG: o_sum = i_acc - i_h;
            default:    o_sum = i_acc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ms2xs_axis_mul.sv
// ============================================================================
// Module  : ms2xs_axis_mul
// Brief   : AXI-Stream cyclic convolution e = h*r (+m) in Z_q[x]/(x^N-1)
//           with M parallel update lanes. Define MS2XS_ADD_M_EN to add m.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ms2xs_axis_mul
    import ms2xs_pkg::*;
#(
    parameter int N       = 11,
    parameter int q       = 64,
    parameter int M       = 1,
    parameter int D_WIDTH = 32
) (
    input  logic               din_axis_aclk,
    input  logic               din_axis_areset,
    input  logic [D_WIDTH-1:0] din_axis_tdata,
    input  logic               din_axis_tvalid,
    input  logic               din_axis_tlast,
    output logic               din_axis_tready,
    output logic [D_WIDTH-1:0] dout_axis_tdata,
    output logic               dout_axis_tvalid,
    output logic               dout_axis_tlast,
    input  logic               dout_axis_tready,
    output logic               mult_done,
    output logic               frame_err
);

    localparam int LOGQ = clog2(q);
    localparam int IW   = (clog2(N) > 0) ? clog2(N) : 1;
    localparam int G    = (N + M - 1) / M;
    localparam int GW   = (clog2(G) > 0) ? clog2(G) : 1;

    localparam logic [IW-1:0] C_LAST_IDX = IW'(N - 1);
    localparam logic [GW-1:0] C_LAST_GRP = GW'(G - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [IW-1:0]   r_cnt;
    logic [IW-1:0]   r_j;
    logic [GW-1:0]   r_grp;
    logic [IW-1:0]   r_ocnt;
    logic            r_tready;
    logic            r_ovalid;
    logic            r_done;
    logic            r_ferr;

    logic [LOGQ-1:0] r_h   [N];
    logic [1:0]      r_r   [N];
    logic [LOGQ-1:0] r_acc [N];

    logic [LOGQ-1:0] w_h_in;
    logic [1:0]      w_r_in;
    logic [1:0]      w_m_in;
    logic [LOGQ-1:0] w_preload;
    logic [1:0]      w_code;
    logic            w_accept;
    logic            w_last_word;
    logic            w_grp_last;
    logic            w_comp_last;
    logic            w_out_hs;
    logic            w_out_last;
    logic            w_unused;

    logic            w_lane_en [M];
    logic [IW-1:0]   w_k       [M];
    logic [IW-1:0]   w_hidx    [M];
    logic [LOGQ-1:0] w_sum     [M];

    assign w_h_in      = din_axis_tdata[LOGQ+3:4];
    assign w_r_in      = din_axis_tdata[3:2];
    assign w_m_in      = din_axis_tdata[1:0];
    assign w_unused    = ^din_axis_tdata;

    assign w_accept    = din_axis_tvalid & r_tready;
    assign w_last_word = (r_cnt == C_LAST_IDX);
    assign w_grp_last  = (r_grp == C_LAST_GRP);
    assign w_comp_last = w_grp_last & (r_j == C_LAST_IDX);
    assign w_out_hs    = r_ovalid & dout_axis_tready;
    assign w_out_last  = (r_ocnt == C_LAST_IDX);
    assign w_code      = r_r[r_j];

`ifdef MS2XS_ADD_M_EN
    always_comb begin
        case (w_m_in)
            C_TRIT_POS: w_preload = LOGQ'(1);
            C_TRIT_NEG: w_preload = '1;
            default:    w_preload = '0;
        endcase
    end
`else
    assign w_preload = '0;
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LOAD:    if (w_accept && w_last_word) w_state_next = ST_COMPUTE;
            ST_COMPUTE: if (w_comp_last)             w_state_next = ST_OUTPUT;
            ST_OUTPUT:  if (w_out_hs && w_out_last)  w_state_next = ST_LOAD;
            default:                                 w_state_next = ST_LOAD;
        endcase
    end

    // Lane l of group g owns accumulator k = g*M + l and reads h[(k-j) mod N].
    always_comb begin
        int kk;
        int hh;
        kk = 0;
        hh = 0;
        for (int l = 0; l < M; l++) begin
            kk = int'(r_grp) * M + l;
            hh = 0;
            w_lane_en[l] = 1'b0;
            if (kk < N) begin
                w_lane_en[l] = 1'b1;
                hh = (kk >= int'(r_j)) ? kk - int'(r_j) : kk + N - int'(r_j);
            end else begin
                kk = 0;
            end
            w_k[l]    = IW'(kk);
            w_hidx[l] = IW'(hh);
        end
    end

    for (genvar l = 0; l < M; l++) begin : g_lane
        ms2xs_au #(
            .LOGQ (LOGQ)
        ) u_au (
            .i_acc  (r_acc[w_k[l]]),
            .i_h    (r_h[w_hidx[l]]),
            .i_code (w_code),
            .o_sum  (w_sum[l])
        );
    end

    always_ff @(posedge din_axis_aclk) begin
        if (din_axis_areset) r_state <= ST_LOAD;
        else                 r_state <= w_state_next;
    end

    always_ff @(posedge din_axis_aclk) begin
        if (w_accept) begin
            r_h[r_cnt] <= w_h_in;
            r_r[r_cnt] <= w_r_in;
        end
    end

    always_ff @(posedge din_axis_aclk) begin
        if (din_axis_areset) begin
            r_cnt    <= '0;
            r_j      <= '0;
            r_grp    <= '0;
            r_ocnt   <= '0;
            r_tready <= 1'b0;
            r_ovalid <= 1'b0;
            r_done   <= 1'b0;
            r_ferr   <= 1'b0;
            for (int i = 0; i < N; i++) r_acc[i] <= '0;
        end else begin
            r_tready <= (w_state_next == ST_LOAD);
            r_done   <= (r_state == ST_COMPUTE) && w_comp_last;
            r_ferr   <= w_accept && din_axis_tlast && !w_last_word;
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_acc[r_cnt] <= w_preload;
                        // An early tlast throws the partial frame away.
                        r_cnt <= (w_last_word || din_axis_tlast) ? '0 : r_cnt + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    for (int l = 0; l < M; l++) begin
                        if (w_lane_en[l]) r_acc[w_k[l]] <= w_sum[l];
                    end
                    if (w_grp_last) begin
                        r_grp <= '0;
                        r_j   <= w_comp_last ? '0 : r_j + 1'b1;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                    if (w_comp_last) begin
                        r_ovalid <= 1'b1;
                        r_ocnt   <= '0;
                    end
                end
                ST_OUTPUT: begin
                    if (w_out_hs) begin
                        if (w_out_last) begin
                            r_ovalid <= 1'b0;
                            r_ocnt   <= '0;
                        end else begin
                            r_ocnt <= r_ocnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign din_axis_tready  = r_tready;
    assign dout_axis_tvalid = r_ovalid;
    assign dout_axis_tdata  = r_ovalid ? {{(D_WIDTH-LOGQ){1'b0}}, r_acc[r_ocnt]} : '0;
    assign dout_axis_tlast  = r_ovalid & w_out_last;
    assign mult_done        = r_done;
    assign frame_err        = r_ferr;

endmodule

`default_nettype wire

// File: tb/tb_ms2xs_axis_mul.sv
// ============================================================================
// Module  : tb_ms2xs_axis_mul
// Brief   : Directed vector bench driving M=1, M=4 and M=11 instances with
//           identical frames; follows MS2XS_ADD_M_EN for the m-add vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ms2xs_axis_mul;

    localparam int N    = 11;
    localparam int Q    = 64;
    localparam int LOGQ = 6;
    localparam int DW   = 32;
    localparam int NV   = 6;

`ifdef MS2XS_ADD_M_EN
    localparam bit M_EN = 1'b1;
`else
    localparam bit M_EN = 1'b0;
`endif

    typedef struct {
        logic [LOGQ-1:0] h [N];
        logic [1:0]      r [N];
        logic [1:0]      m [N];
        logic [LOGQ-1:0] e [N];
        bit              tog;
    } vec_t;

    vec_t vecs [NV];
    int   exp_lat [3] = '{121, 33, 11};

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  din_tdata = '0;
    logic           din_tvalid = 1'b0;
    logic           din_tlast = 1'b0;
    logic [2:0]     din_tready, dout_tvalid, dout_tlast, mult_done, frame_err, rdy;
    logic [DW-1:0]  dout_tdata [3];
    logic           rdy0 = 1'b1;
    bit             tog_en = 1'b0;

    always #5 clk = ~clk;
    assign rdy = {2'b11, rdy0};

    ms2xs_axis_mul #(.N(N), .q(Q), .M(1), .D_WIDTH(DW)) u_dut (
        .din_axis_aclk(clk), .din_axis_areset(rst),
        .din_axis_tdata(din_tdata), .din_axis_tvalid(din_tvalid),
        .din_axis_tlast(din_tlast), .din_axis_tready(din_tready[0]),
        .dout_axis_tdata(dout_tdata[0]), .dout_axis_tvalid(dout_tvalid[0]),
        .dout_axis_tlast(dout_tlast[0]), .dout_axis_tready(rdy0),
        .mult_done(mult_done[0]), .frame_err(frame_err[0]));

    ms2xs_axis_mul #(.N(N), .q(Q), .M(4), .D_WIDTH(DW)) u_dut_m4 (
        .din_axis_aclk(clk), .din_axis_areset(rst),
        .din_axis_tdata(din_tdata), .din_axis_tvalid(din_tvalid),
        .din_axis_tlast(din_tlast), .din_axis_tready(din_tready[1]),
        .dout_axis_tdata(dout_tdata[1]), .dout_axis_tvalid(dout_tvalid[1]),
        .dout_axis_tlast(dout_tlast[1]), .dout_axis_tready(1'b1),
        .mult_done(mult_done[1]), .frame_err(frame_err[1]));

    ms2xs_axis_mul #(.N(N), .q(Q), .M(11), .D_WIDTH(DW)) u_dut_m11 (
        .din_axis_aclk(clk), .din_axis_areset(rst),
        .din_axis_tdata(din_tdata), .din_axis_tvalid(din_tvalid),
        .din_axis_tlast(din_tlast), .din_axis_tready(din_tready[2]),
        .dout_axis_tdata(dout_tdata[2]), .dout_axis_tvalid(dout_tvalid[2]),
        .dout_axis_tlast(dout_tlast[2]), .dout_axis_tready(1'b1),
        .mult_done(mult_done[2]), .frame_err(frame_err[2]));

    int              cyc = 0;
    int              n_checks = 0;
    int              n_errors = 0;
    int              got_cnt [3];
    logic [LOGQ-1:0] got_d   [3][32];
    bit              got_l   [3][32];
    int              done_cnt [3];
    int              done_cyc [3];
    int              acc_cyc  [3];
    int              ferr_cnt [3];
    bit              drv_final = 1'b0;
    bit              stall_prev = 1'b0;
    bit              last_hs_prev = 1'b0;
    int              stall_data = 0;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #2;
        rdy0 = tog_en ? ~rdy0 : 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Handshakes complete at the following rising edge.
    always @(negedge clk) begin
        if (stall_prev) begin
            chk("hold_tvalid", int'(dout_tvalid[0]), 1);
            chk("hold_tdata", int'(dout_tdata[0]), stall_data);
        end
        if (last_hs_prev) chk("b2b_tready", int'(din_tready[0]), 1);
        stall_prev   = dout_tvalid[0] && !rdy0 && !rst;
        stall_data   = int'(dout_tdata[0]);
        last_hs_prev = dout_tvalid[0] && rdy0 && dout_tlast[0] && !rst;
        for (int d = 0; d < 3; d++) begin
            if (dout_tvalid[d] && rdy[d]) begin
                if (got_cnt[d] < 32) begin
                    got_d[d][got_cnt[d]] = dout_tdata[d][LOGQ-1:0];
                    got_l[d][got_cnt[d]] = dout_tlast[d];
                end
                got_cnt[d]++;
            end
            if (mult_done[d]) begin
                done_cnt[d]++;
                done_cyc[d] = cyc;
            end
            if (frame_err[d]) ferr_cnt[d]++;
            if (din_tvalid && din_tready[d] && drv_final) acc_cyc[d] = cyc + 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 3; d++) begin
            got_cnt[d]  = 0;
            done_cnt[d] = 0;
            ferr_cnt[d] = 0;
            done_cyc[d] = -1;
            acc_cyc[d]  = -1;
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (din_tready != 3'b111 && t < 2000) begin
            step();
            t++;
        end
        chk("wait_ready", int'(din_tready), 7);
    endtask

    task automatic drive_frame(input int vi, input int nwords, input bit bad);
        logic [DW-1:0] w;
        for (int i = 0; i < nwords; i++) begin
            w = '0;
            w[LOGQ+3:4] = vecs[vi].h[i];
            w[3:2]      = vecs[vi].r[i];
            w[1:0]      = vecs[vi].m[i];
            din_tdata   = w;
            din_tvalid  = 1'b1;
            din_tlast   = (i == nwords - 1);
            drv_final   = !bad && (i == N - 1);
            step();
        end
        din_tvalid = 1'b0;
        din_tlast  = 1'b0;
        drv_final  = 1'b0;
    endtask

    task automatic run_vec(input int vi);
        int t;
        clear_counts();
        tog_en = vecs[vi].tog;
        wait_ready();
        drive_frame(vi, N, 1'b0);
        t = 0;
        while ((got_cnt[0] < N || got_cnt[1] < N || got_cnt[2] < N) && t < 3000) begin
            step();
            t++;
        end
        repeat (3) step();
        tog_en = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("v%0d d%0d out_count", vi, d), got_cnt[d], N);
            chk($sformatf("v%0d d%0d done_count", vi, d), done_cnt[d], 1);
            chk($sformatf("v%0d d%0d latency", vi, d), done_cyc[d] - acc_cyc[d], exp_lat[d]);
            for (int k = 0; k < N; k++) begin
                chk($sformatf("v%0d d%0d e%0d", vi, d, k), int'(got_d[d][k]), int'(vecs[vi].e[k]));
                chk($sformatf("v%0d d%0d tlast%0d", vi, d, k), int'(got_l[d][k]), (k == N - 1) ? 1 : 0);
            end
        end
    endtask

    initial begin
        for (int v = 0; v < NV; v++) begin
            for (int i = 0; i < N; i++) begin
                vecs[v].h[i] = '0;
                vecs[v].r[i] = 2'b00;
                vecs[v].m[i] = 2'b00;
                vecs[v].e[i] = '0;
            end
            vecs[v].tog = 1'b0;
        end
        // single impulse: h0=5, r2=+1 -> e2=5
        vecs[0].h[0] = 6'd5;  vecs[0].r[2] = 2'b01; vecs[0].e[2] = 6'd5;
        // index wrap: h10=1, r1=+1 -> e0=1
        vecs[1].h[10] = 6'd1; vecs[1].r[1] = 2'b01; vecs[1].e[0] = 6'd1; vecs[1].tog = 1'b1;
        // negative wrap: h0=1, r0=-1 -> e0=63
        vecs[2].h[0] = 6'd1;  vecs[2].r[0] = 2'b11; vecs[2].e[0] = 6'd63;
        // m add: h=0, m3=-1
        vecs[3].m[3] = 2'b11; vecs[3].e[3] = M_EN ? 6'd63 : 6'd0;
        // mixed frame with a reserved code on r5
        vecs[4].h[0] = 6'd3; vecs[4].h[1] = 6'd7; vecs[4].h[2] = 6'd60;
        vecs[4].r[0] = 2'b01; vecs[4].r[1] = 2'b11; vecs[4].r[3] = 2'b01; vecs[4].r[5] = 2'b10;
        vecs[4].e[0] = 6'd3; vecs[4].e[1] = 6'd4; vecs[4].e[2] = 6'd53;
        vecs[4].e[3] = 6'd7; vecs[4].e[4] = 6'd7; vecs[4].e[5] = 6'd60;
        vecs[4].tog = 1'b1;
        // all 63 times all +1 -> 11*63 mod 64 = 53
        for (int i = 0; i < N; i++) begin
            vecs[5].h[i] = 6'd63; vecs[5].r[i] = 2'b01; vecs[5].e[i] = 6'd53;
        end

        clear_counts();
        repeat (3) step();
        chk("rst_tready", int'(din_tready), 0);
        chk("rst_tvalid", int'(dout_tvalid), 0);
        chk("rst_tlast", int'(dout_tlast), 0);
        chk("rst_tdata0", int'(dout_tdata[0]), 0);
        chk("rst_done", int'(mult_done), 0);
        chk("rst_ferr", int'(frame_err), 0);
        rst = 1'b0;
        step();
        chk("post_rst_tready", int'(din_tready), 7);

        for (int v = 0; v < NV; v++) run_vec(v);

        // early tlast on word 5
        wait_ready();
        clear_counts();
        drive_frame(4, 6, 1'b1);
        @(negedge clk);
        chk("ferr_pulse", int'(frame_err), 7);
        repeat (20) step();
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("ferr_count d%0d", d), ferr_cnt[d], 1);
            chk($sformatf("ferr_no_out d%0d", d), got_cnt[d], 0);
            chk($sformatf("ferr_no_done d%0d", d), done_cnt[d], 0);
        end
        chk("ferr_stay_load", int'(din_tready), 7);
        run_vec(0);

        // reset in the middle of COMPUTE
        wait_ready();
        clear_counts();
        drive_frame(4, N, 1'b0);
        repeat (20) step();
        rst = 1'b1;
        step();
        step();
        chk("midrst_tready", int'(din_tready), 0);
        chk("midrst_tvalid", int'(dout_tvalid), 0);
        chk("midrst_tdata0", int'(dout_tdata[0]), 0);
        chk("midrst_done", int'(mult_done), 0);
        chk("midrst_ferr", int'(frame_err), 0);
        chk("midrst_done_cnt0", done_cnt[0], 0);
        chk("midrst_done_cnt1", done_cnt[1], 0);
        rst = 1'b0;
        repeat (150) step();
        chk("midrst_no_done0", done_cnt[0], 0);
        chk("midrst_no_out0", got_cnt[0], 0);
        chk("midrst_no_out1", got_cnt[1], 0);
        run_vec(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
